sha256_job_scheduler: RTL
=========================

# sha256_job_scheduler

Round-robin job scheduler that shares one `simplified_sha256` hash core between `NUM_REQ` requesters. Each requester posts a message address and an output address. The scheduler grants one job at a time and drives the core's `start`, `message_addr` and `output_addr`. It tracks the core's `done` level through the busy-then-idle sequence and returns a per-requester completion pulse, with a watchdog error if the core stalls. It sits between the mining/test control logic and the hash core; the core's memory port is not touched.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 4096: maximum cycles allowed in WAIT_DONE before an error is declared.
- `START_WAIT`, 8: maximum cycles allowed in WAIT_BUSY for `core_done` to fall.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: level request; bit i is held high until `ack[i]`.
- `req_msg_addr` in 16*NUM_REQ: packed; slice i is requester i's message word address.
- `req_out_addr` in 16*NUM_REQ: packed; slice i is requester i's output word address.
- `ack` out NUM_REQ: one-cycle completion pulse for the granted requester.
- `err` out NUM_REQ: one-cycle pulse coincident with `ack` when the job hit a watchdog timeout.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_message_addr` out 16: latched message address.
- `core_output_addr` out 16: latched output address.
- `core_done` in 1: core idle level (high whenever the core is in IDLE, including after reset).
- `busy` out 1: high in every state except IDLE.
- `grant_id` out $clog2(NUM_REQ): index of the current or last granted requester.
- `jobs_done` out 16: count of completed jobs, error jobs included; wraps 0xFFFF→0.

## Operation
- All outputs are registered. Reset values:
  - state IDLE
  - `ack`, `err`, `core_start`, `busy` = 0
  - `core_message_addr`, `core_output_addr` = 0
  - `grant_id` = 0
  - `jobs_done` = 0
  - round-robin pointer `last` = NUM_REQ-1
- States:
  - **IDLE:** if `core_done`=1 and `req`≠0, pick the first set bit searching `last+1, last+2, …` modulo NUM_REQ. Latch that index into `grant_id` and latch its address slices into the core address outputs. Go to START. If `core_done`=0, no grant is made.
  - **START:** `core_start`=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT_BUSY.
  - **WAIT_BUSY:**
    - `core_done`=0 → clear counter, go to WAIT_DONE.
    - Counter reaches START_WAIT-1 with `core_done` still 1 → set error flag, go to RESP.
  - **WAIT_DONE:**
    - `core_done`=1 → go to RESP.
    - Counter reaches TIMEOUT-1 → set error flag, go to RESP.
  - **RESP:** `ack[grant_id]`=1; `err[grant_id]` = error flag. Set `last` = `grant_id`, increment `jobs_done`, clear error flag. Go to IDLE.
- Core address outputs hold their value from START through RESP and keep it in IDLE until the next grant.
- Watchdog counter is 16 bits wide and saturates; it never wraps during a job.
- `req[i]` dropping mid-job is ignored: the job completes and `ack[i]` still pulses. Requests arriving during a job wait for IDLE.
- A requester that was just acked has the lowest priority on the next arbitration.
- `reset_n` asserted in any state returns the block to reset values immediately. Any in-flight job is abandoned with no `ack`.

## Timing
- Request seen high at edge E0 in IDLE → START (`core_start` high) in cycle E0+1 → WAIT_BUSY from E0+2.
- `core_done` seen low at an edge → WAIT_DONE next cycle. `core_done` seen high in WAIT_DONE at edge En → `ack` high in cycle En+1 → IDLE at En+2.
- Minimum job overhead is 4 scheduler cycles plus the core busy time. A back-to-back grant is possible in the first IDLE cycle.
- Requesters drop `req[i]` in the cycle after they observe `ack[i]`. Since IDLE arbitrates at its closing edge, no duplicate grant occurs.
- `busy` rises in START and falls on entry to IDLE.

## Test plan
- **Single job:** `req`=0001, msg=0x0000, out=0x0100, core model busy 150 cycles. Expect `core_start` 1 cycle later, core addresses = 0x0000/0x0100, `ack`=0001 one cycle after `core_done` rises, `err`=0, `jobs_done`=1.
- **Round-robin:** `req`=1111 held, re-raised after each ack. Expect grant order 0,1,2,3,0 and `jobs_done`=5. With `req`=0101 after the grant to 0, next grant is 2.
- **Core not idle:** hold `core_done`=0 with `req`=0010. Expect no `core_start`. Raise `core_done` → `core_start` 2 cycles later.
- **Start watchdog:** core model never drops `core_done`. Expect RESP after START_WAIT cycles with `ack`=`err`=requester bit.
- **Done watchdog:** with TIMEOUT=64, core stays busy forever. Expect `ack`+`err` 64 cycles after WAIT_DONE entry, then the next requester is granted.
- **Reset mid-job:** assert `reset_n`=0 in WAIT_DONE. Expect all outputs at reset values that same cycle, no `ack`, and after release requester 0 wins first.

Source files
------------

// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler: round-robin arbiter sharing one hash core between NUM_REQ requesters,
// with start/done watchdogs and per-requester completion/error pulses.
module sha256_job_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 4096,
    parameter int START_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [16*NUM_REQ-1:0]      req_msg_addr,
    input  logic [16*NUM_REQ-1:0]      req_out_addr,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         err,
    output logic                       core_start,
    output logic [15:0]                core_message_addr,
    output logic [15:0]                core_output_addr,
    input  logic                       core_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [15:0]                jobs_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [15:0] TO_MAX = 16'(TIMEOUT - 1);
    localparam logic [15:0] SW_MAX = 16'(START_WAIT - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt, cnt_inc;
    logic eflag, eflag_nxt, found;
    logic [IW-1:0] last, last_nxt, grant_nxt, pick, cand;
    logic [15:0] msg_sel, out_sel, msg_nxt, out_nxt, jobs_nxt;
    logic [NUM_REQ-1:0] grant_oh;

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // Scan from the farthest offset down so the nearest requester after last wins.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand     = '0;
        msg_sel  = '0;
        out_sel  = '0;
        grant_oh = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i)) begin
                msg_sel = req_msg_addr[i*16 +: 16];
                out_sel = req_out_addr[i*16 +: 16];
            end
            grant_oh[i] = (grant_id == IW'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        eflag_nxt = eflag;
        last_nxt  = last;
        grant_nxt = grant_id;
        msg_nxt   = core_message_addr;
        out_nxt   = core_output_addr;
        jobs_nxt  = jobs_done;
        case (state)
            IDLE: if (core_done && found) begin
                state_nxt = START;
                grant_nxt = pick;
                msg_nxt   = msg_sel;
                out_nxt   = out_sel;
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: if (!core_done) begin
                cnt_nxt   = '0;
                state_nxt = WAIT_DONE;
            end else if (cnt == SW_MAX) begin
                eflag_nxt = 1'b1;
                state_nxt = RESP;
            end else begin
                cnt_nxt = cnt_inc;
            end
            WAIT_DONE: if (core_done) begin
                state_nxt = RESP;
            end else if (cnt == TO_MAX) begin
                eflag_nxt = 1'b1;
                state_nxt = RESP;
            end else begin
                cnt_nxt = cnt_inc;
            end
            RESP: begin
                last_nxt  = grant_id;
                jobs_nxt  = jobs_done + 16'd1;
                eflag_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            eflag             <= 1'b0;
            last              <= IW'(NUM_REQ - 1);
            grant_id          <= '0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
            jobs_done         <= '0;
            core_start        <= 1'b0;
            busy              <= 1'b0;
            ack               <= '0;
            err               <= '0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            eflag             <= eflag_nxt;
            last              <= last_nxt;
            grant_id          <= grant_nxt;
            core_message_addr <= msg_nxt;
            core_output_addr  <= out_nxt;
            jobs_done         <= jobs_nxt;
            core_start        <= (state_nxt == START);
            busy              <= (state_nxt != IDLE);
            ack               <= (state_nxt == RESP) ? grant_oh : '0;
            err               <= (state_nxt == RESP && eflag_nxt) ? grant_oh : '0;
        end
    end
endmodule
